// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, line levels and bit-timing helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic UART_STOP_LEVEL = 1'b1;

    function automatic int clks_per_bit(input int sys_clk, input int baud);
        return sys_clk / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value selectable.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: mid-bit sampling, stop-bit check, valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int BAUD      = 9600,
    parameter int SYS_CLK   = 12000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rx_wire,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state_r, state_next_s;
    logic [CNT_W-1:0]     baud_cnt_r, baud_cnt_next_s;
    logic [IDX_W-1:0]     bit_idx_r, bit_idx_next_s;
    logic [DATA_BITS-1:0] shift_r, shift_next_s;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 framing_error_r;
    logic                 overrun_r;
    logic                 busy_r;
    logic                 load_s;
    logic                 fe_s;
    logic                 ovr_s;

    uart_sync #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx_wire),
        .sync_out (rx_s)
    );

    // Next-state, bit timing and stop-bit decision
    always_comb begin
        state_next_s    = state_r;
        baud_cnt_next_s = baud_cnt_r + CNT_W'(1);
        bit_idx_next_s  = bit_idx_r;
        shift_next_s    = shift_r;
        load_s          = 1'b0;
        fe_s            = 1'b0;
        ovr_s           = 1'b0;
        if (!enable) begin
            state_next_s    = IDLE;
            baud_cnt_next_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_next_s = '0;
                    if (rx_s != UART_IDLE_LEVEL) begin
                        state_next_s = START;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                START: begin
                    if (baud_cnt_r == HALF_LAST) begin
                        baud_cnt_next_s = '0;
                        bit_idx_next_s  = '0;
                        // A start bit that has gone high again by mid-bit was a glitch
                        if (rx_s == UART_IDLE_LEVEL) begin
                            state_next_s = IDLE;
                        end else begin
                            state_next_s = DATA;
                        end
                    end else begin
                        state_next_s = START;
                    end
                end
                DATA: begin
                    if (baud_cnt_r == BIT_LAST) begin
                        baud_cnt_next_s         = '0;
                        shift_next_s[bit_idx_r] = rx_s;
                        if (bit_idx_r == IDX_LAST) begin
                            state_next_s = STOP;
                        end else begin
                            bit_idx_next_s = bit_idx_r + IDX_W'(1);
                        end
                    end else begin
                        state_next_s = DATA;
                    end
                end
                STOP: begin
                    if (baud_cnt_r == BIT_LAST) begin
                        // Leave at mid-stop so an immediately following start bit is caught
                        baud_cnt_next_s = '0;
                        state_next_s    = IDLE;
                        if (rx_s == UART_STOP_LEVEL) begin
                            if (!rx_valid_r || rx_ready) begin
                                load_s = 1'b1;
                            end else begin
                                ovr_s = 1'b1;
                            end
                        end else begin
                            fe_s = 1'b1;
                        end
                    end else begin
                        state_next_s = STOP;
                    end
                end
                default: begin
                    state_next_s    = IDLE;
                    baud_cnt_next_s = '0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            baud_cnt_r      <= '0;
            bit_idx_r       <= '0;
            shift_r         <= '0;
            rx_data_r       <= '0;
            rx_valid_r      <= 1'b0;
            framing_error_r <= 1'b0;
            overrun_r       <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            baud_cnt_r      <= baud_cnt_next_s;
            bit_idx_r       <= bit_idx_next_s;
            shift_r         <= shift_next_s;
            framing_error_r <= fe_s;
            overrun_r       <= ovr_s;
            busy_r          <= (state_next_s != IDLE);
            if (load_s) begin
                rx_data_r  <= shift_r;
                rx_valid_r <= 1'b1;
            end else if (rx_ready) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign rx_data       = rx_data_r;
    assign rx_valid      = rx_valid_r;
    assign framing_error = framing_error_r;
    assign overrun       = overrun_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at a reduced bit period (16 clk per bit).
module tb_uart_rx;

    localparam int DATA_BITS = 8;
    localparam int BAUD      = 10;
    localparam int SYS_CLK   = 160;
    localparam int CPB       = SYS_CLK / BAUD;
    localparam int LATENCY   = 2 + CPB / 2 + DATA_BITS * CPB + CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rx_wire;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int fe_cnt = 0, ovr_cnt = 0, rise_cnt = 0, busy_cnt = 0;
    logic valid_q = 1'b0;
    int fe0, ovr0, rise0, busy0, lat;

    uart_rx #(.DATA_BITS(DATA_BITS), .BAUD(BAUD), .SYS_CLK(SYS_CLK)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .rx_wire       (rx_wire),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled on the inactive edge
    always @(negedge clk) begin
        fe_cnt   <= fe_cnt + int'(framing_error);
        ovr_cnt  <= ovr_cnt + int'(overrun);
        busy_cnt <= busy_cnt + int'(busy);
        valid_q  <= rx_valid;
        if (rx_valid && !valid_q) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_wire = b;
        tick(CPB);
    endtask

    task automatic send_head(input logic [7:0] d, input int n);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_head(d, 8);
        send_bit(stop);
        rx_wire = 1'b1;
    endtask

    task automatic snap();
        tick(1);
        fe0 = fe_cnt; ovr0 = ovr_cnt; rise0 = rise_cnt; busy0 = busy_cnt;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; rx_wire = 1'b1; rx_ready = 1'b0;
        tick(3);
        check_eq("rst_data", 32'(rx_data), 32'h0);
        check_eq("rst_valid", 32'(rx_valid), 32'h0);
        check_eq("rst_fe", 32'(framing_error), 32'h0);
        check_eq("rst_ovr", 32'(overrun), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0; enable = 1'b1;

        // Idle line, consumer ready: nothing should happen
        rx_ready = 1'b1;
        snap();
        tick(20 * CPB);
        check_eq("idle_valid", 32'(rise_cnt - rise0), 32'h0);
        check_eq("idle_fe", 32'(fe_cnt - fe0), 32'h0);
        check_eq("idle_ovr", 32'(ovr_cnt - ovr0), 32'h0);
        check_eq("idle_busy", 32'(busy_cnt - busy0), 32'h0);
        rx_ready = 1'b0;

        // 0xA5 with consumer stalled, then a one-cycle accept
        send_frame(8'hA5, 1'b1);
        tick(2 * CPB);
        check_eq("a5_valid", 32'(rx_valid), 32'h1);
        check_eq("a5_data", 32'(rx_data), 32'hA5);
        lat = rise_cyc - start_cyc;
        check_eq("a5_latency", 32'(lat >= LATENCY - 1 && lat <= LATENCY + 1), 32'h1);
        tick(5);
        check_eq("a5_hold", 32'(rx_valid), 32'h1);
        consume();
        check_eq("a5_cleared", 32'(rx_valid), 32'h0);
        check_eq("a5_data_kept", 32'(rx_data), 32'hA5);

        // Short low glitch: false start
        snap();
        rx_wire = 1'b0;
        tick(4);
        check_eq("glitch_busy_hi", 32'(busy), 32'h1);
        rx_wire = 1'b1;
        tick(3 * CPB);
        check_eq("glitch_busy_lo", 32'(busy), 32'h0);
        check_eq("glitch_valid", 32'(rise_cnt - rise0), 32'h0);
        check_eq("glitch_fe", 32'(fe_cnt - fe0), 32'h0);

        // Bad stop bit, then the same word correctly framed
        snap();
        send_frame(8'h3C, 1'b0);
        tick(2 * CPB);
        check_eq("fe_pulse", 32'(fe_cnt - fe0), 32'h1);
        check_eq("fe_valid", 32'(rx_valid), 32'h0);
        send_frame(8'h3C, 1'b1);
        tick(CPB);
        check_eq("3c_valid", 32'(rx_valid), 32'h1);
        check_eq("3c_data", 32'(rx_data), 32'h3C);
        check_eq("3c_no_fe", 32'(fe_cnt - fe0), 32'h1);
        consume();

        // Back-to-back frames with consumer stalled: second one overruns
        snap();
        send_frame(8'h81, 1'b1);
        send_frame(8'h7E, 1'b1);
        tick(CPB);
        check_eq("ovr_pulse", 32'(ovr_cnt - ovr0), 32'h1);
        check_eq("ovr_data", 32'(rx_data), 32'h81);
        check_eq("ovr_valid", 32'(rx_valid), 32'h1);
        consume();
        check_eq("ovr_cleared", 32'(rx_valid), 32'h0);
        check_eq("ovr_data_kept", 32'(rx_data), 32'h81);

        // Reset in the middle of data bit 4 of 0xFF
        snap();
        send_head(8'hFF, 4);
        rx_wire = 1'b1;
        tick(CPB / 2);
        check_eq("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("mrst_data", 32'(rx_data), 32'h0);
        check_eq("mrst_valid", 32'(rx_valid), 32'h0);
        check_eq("mrst_busy", 32'(busy), 32'h0);
        tick(6 * CPB);
        check_eq("mrst_no_frame", 32'(rise_cnt - rise0), 32'h0);
        send_frame(8'h55, 1'b1);
        tick(CPB);
        check_eq("55_valid", 32'(rx_valid), 32'h1);
        check_eq("55_data", 32'(rx_data), 32'h55);
        consume();

        // Enable dropped mid-frame
        snap();
        send_head(8'hC3, 4);
        check_eq("en_busy_hi", 32'(busy), 32'h1);
        enable = 1'b0;
        tick(1);
        check_eq("en_busy_lo", 32'(busy), 32'h0);
        for (int i = 4; i < 8; i++) send_bit(1'(8'hC3 >> i));
        send_bit(1'b1);
        tick(2);
        enable = 1'b1;
        tick(2 * CPB);
        check_eq("en_no_valid", 32'(rise_cnt - rise0), 32'h0);
        check_eq("en_no_fe", 32'(fe_cnt - fe0), 32'h0);
        check_eq("en_data_kept", 32'(rx_data), 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
